shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle variable shifter controller for the ARM processor datapath. It accepts a 64-bit operand, a shift opcode and a shift amount, then iterates a coarse fixed-step shift stage and a 1-bit shift stage until the requested amount has been applied. It completes LSL/LSR/ASR/ROR without a full barrel shifter. It sits beside the ALU and is driven by the execute-stage control through a start/busy/done handshake.

## Interface
- WIDTH, 64, operand and result width in bits
- STEP, 4, coarse shift distance applied per cycle; power of two, 2 ≤ STEP ≤ WIDTH/2
- AMT_BITS, $clog2(WIDTH), width of the shift-amount input
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- amt  input  AMT_BITS  shift amount, 0..WIDTH-1
- in  input  WIDTH  operand
- out  output  WIDTH  result register
- busy  output  1  high while not IDLE (SHIFT or DONE)
- done  output  1  one-cycle pulse; out is valid in this cycle

## Operation
- Internal registers:
  - state: IDLE, SHIFT or DONE
  - acc: WIDTH bits
  - rem: AMT_BITS bits
  - op_q: 2 bits
- IDLE:
  - On start=1, latch acc←in, op_q←op and rem←amt.
  - If amt==0, go to DONE. Otherwise go to SHIFT.
  - With start=0, stay in IDLE.
- SHIFT, one step per cycle:
  - If rem ≥ STEP, shift acc by STEP and set rem←rem−STEP.
  - Otherwise, shift acc by 1 and set rem←rem−1.
  - If the new rem==0, go to DONE. Otherwise stay in SHIFT.
- Shift semantics, per step of k bits:
  - LSL: zero-fill the low bits.
  - LSR: zero-fill the high bits.
  - ASR: fill the high bits with acc[WIDTH-1].
  - ROR: the low k bits wrap into the top.
- DONE:
  - Copy out←acc on the transition into DONE, so out is valid throughout DONE.
  - Assert done. Return to IDLE on the next edge unconditionally.
- Output holding: out holds its value after DONE until the next completed operation.
- start handling: start is ignored in SHIFT and DONE. No queuing: a request raised while busy is lost unless it is held into IDLE.
- Operand stability: in, op and amt are don't-care after the start edge. Only latched values are used.
- Width rule: amt ≥ WIDTH is not representable for power-of-two WIDTH; there is no saturation logic.
- Reset, synchronous, has priority over everything:
  - state←IDLE
  - acc←0, rem←0, op_q←00
  - out←0
  - busy=0, done=0
- Reset mid-operation aborts the shift. out returns to 0 and no done pulse is issued.

## Timing
- Step count: N = amt/STEP + amt%STEP (integer division).
- Shift schedule: the start edge is E0. Shifts occur on edges E1..EN.
- done: high for exactly one cycle, the cycle following edge EN. For amt==0 (N=0) this is the cycle following E0.
- Latency: start cycle to done cycle is N+1 cycles.
- busy: high from the cycle after E0 through the done cycle inclusive. It is low in the cycle after done.
- Back-to-back operation:
  - A start held high into the first IDLE cycle after done is accepted. Minimum issue interval is N+2 cycles.
  - busy and done are registered outputs with no combinational path from start.
- Worst case: amt=WIDTH−1 gives N=(WIDTH−1)/STEP + (WIDTH−1)%STEP. For 64 with STEP 4 this is 15+3=18.

## Test plan
- amt=0: LSL, in=6, amt=0 → done in the cycle after the start edge, out=6, busy high for exactly 1 cycle.
- Short LSL: in=6, amt=2 → N=2, done 3 cycles after start, out=24. Then in=−2, amt=5 with ASR → N=2, out=0xFFFF_FFFF_FFFF_FFFF.
- Full-span LSR: in=0x8000_0000_0000_0000, amt=63 → N=18, done at cycle 19, out=1. busy continuous from cycle 1 to 19.
- Rotate: ROR, in=1, amt=1 → out=0x8000_0000_0000_0000. ROR, in=0x0F, amt=4 → out=0xF000_0000_0000_0000.
- start while busy: pulse start with different in/amt during SHIFT and during DONE → ignored, first result unchanged. A start held high into IDLE is accepted the next cycle.
- Reset mid-operation: assert reset at edge E3 of an amt=63 LSR → the next cycle has busy=0, done=0, out=0. No done pulse follows, and a new start works normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter: applies a coarse STEP-bit shift per cycle
// while the remaining amount allows it, then finishes with 1-bit shifts.
module shift_sequencer #(
    parameter int WIDTH    = 64,
    parameter int STEP     = 4,
    parameter int AMT_BITS = $clog2(WIDTH)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [1:0]          i_op,
    input  logic [AMT_BITS-1:0] i_amt,
    input  logic [WIDTH-1:0]    i_in,
    output logic [WIDTH-1:0]    o_out,
    output logic                o_busy,
    output logic                o_done
);

    // state   | meaning
    // S_IDLE  | waiting for i_start; latches operands on acceptance
    // S_SHIFT | one coarse or single-bit step per cycle until r_rem reaches 0
    // S_DONE  | o_out valid, o_done pulsed for this one cycle
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [AMT_BITS-1:0] STEP_A = AMT_BITS'(STEP);
    localparam logic [AMT_BITS-1:0] ONE_A  = AMT_BITS'(1);

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_acc, w_acc_nxt;
    logic [WIDTH-1:0]    r_out, w_out_nxt;
    logic [AMT_BITS-1:0] r_rem, w_rem_nxt;
    logic [1:0]          r_op, w_op_nxt;
    logic [WIDTH-1:0]    w_sh_step, w_sh_one, w_sh;
    logic [AMT_BITS-1:0] w_rem_dec;
    logic                w_coarse;

    // k is always a constant at the call sites, so each call is plain wiring
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] a,
                                                  input logic [1:0]       op,
                                                  input int               k);
        case (op)
            2'b00:   shift_by = a << k;
            2'b01:   shift_by = a >> k;
            2'b10:   shift_by = WIDTH'($signed(a) >>> k);
            default: shift_by = (a >> k) | (a << (WIDTH - k));
        endcase
    endfunction

    always_comb begin
        w_coarse    = (r_rem >= STEP_A);
        w_sh_step   = shift_by(r_acc, r_op, STEP);
        w_sh_one    = shift_by(r_acc, r_op, 1);
        w_sh        = w_coarse ? w_sh_step : w_sh_one;
        w_rem_dec   = w_coarse ? (r_rem - STEP_A) : (r_rem - ONE_A);

        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_out_nxt   = r_out;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_acc_nxt = i_in;
                    w_op_nxt  = i_op;
                    w_rem_nxt = i_amt;
                    if (i_amt == '0) begin
                        w_state_nxt = S_DONE;
                        w_out_nxt   = i_in;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_acc_nxt = w_sh;
                w_rem_nxt = w_rem_dec;
                if (w_rem_dec == '0) begin
                    w_state_nxt = S_DONE;
                    w_out_nxt   = w_sh;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        o_busy = (r_state != S_IDLE);
        o_done = (r_state == S_DONE);
        o_out  = r_out;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_out   <= '0;
            r_rem   <= '0;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_out   <= w_out_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table for result/latency/busy,
// plus hand-written sequences for start-while-busy and mid-operation reset.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  amt;
    logic [63:0] din;
    logic [63:0] dout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(64), .STEP(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_amt   (amt),
        .i_in    (din),
        .o_out   (dout),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  amt;
        logic [63:0] din;
        logic [63:0] exp;
        int          n;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [1:0] o, input logic [5:0] a,
                          input logic [63:0] d, input logic [63:0] exp, input int n);
        int cyc;
        bit busy_ok;
        string tag;
        tag   = $sformatf("v%0d", idx);
        start = 1'b1;
        op    = o;
        amt   = a;
        din   = d;
        step();
        start   = 1'b0;
        op      = ~o;
        amt     = ~a;
        din     = ~d;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(n + 1));
        chk({tag, "_out"}, dout, exp);
        chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        step();
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_done_after"}, 64'(done), 64'd0);
        chk({tag, "_out_hold"}, dout, exp);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 6'd0,  64'd6,                  64'd6,                  0};
        vecs[1]  = '{2'b00, 6'd2,  64'd6,                  64'd24,                 2};
        vecs[2]  = '{2'b10, 6'd5,  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[3]  = '{2'b01, 6'd63, 64'h8000_0000_0000_0000, 64'd1,                  18};
        vecs[4]  = '{2'b11, 6'd1,  64'd1,                  64'h8000_0000_0000_0000, 1};
        vecs[5]  = '{2'b11, 6'd4,  64'h0F,                 64'hF000_0000_0000_0000, 1};
        vecs[6]  = '{2'b00, 6'd63, 64'd1,                  64'h8000_0000_0000_0000, 18};
        vecs[7]  = '{2'b10, 6'd63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 18};
        vecs[8]  = '{2'b11, 6'd8,  64'h1234_5678_9ABC_DEF0, 64'hF012_3456_789A_BCDE, 2};
        vecs[9]  = '{2'b01, 6'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'h01FF_FFFF_FFFF_FFFF, 4};
        vecs[10] = '{2'b10, 6'd3,  64'h4000_0000_0000_0000, 64'h0800_0000_0000_0000, 3};
        vecs[11] = '{2'b11, 6'd63, 64'd1,                  64'd2,                  18};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        amt   = 6'd0;
        din   = 64'd0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out",  dout,      64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++)
            run_op(i, vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp, vecs[i].n);

        // start pulsed during SHIFT and held through DONE into IDLE
        start = 1'b1; op = 2'b00; amt = 6'd9; din = 64'd3;
        step();
        start = 1'b1; amt = 6'd1; din = 64'hFF;
        step();
        start = 1'b0;
        chk("sb_c2_done", 64'(done), 64'd0);
        step();
        chk("sb_c3_done", 64'(done), 64'd0);
        chk("sb_c3_busy", 64'(busy), 64'd1);
        step();
        chk("sb_c4_done", 64'(done), 64'd1);
        chk("sb_c4_out",  dout,      64'h600);
        start = 1'b1; op = 2'b00; amt = 6'd0; din = 64'd5;
        step();
        chk("sb_c5_busy", 64'(busy), 64'd0);
        chk("sb_c5_done", 64'(done), 64'd0);
        chk("sb_c5_out",  dout,      64'h600);
        step();
        start = 1'b0;
        chk("sb_c6_done", 64'(done), 64'd1);
        chk("sb_c6_out",  dout,      64'd5);
        step();
        chk("sb_c7_busy", 64'(busy), 64'd0);

        // reset asserted at edge E3 of a long LSR
        start = 1'b1; op = 2'b01; amt = 6'd63; din = 64'h8000_0000_0000_0000;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_done", 64'(done), 64'd0);
        chk("rm_out",  dout,      64'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 25; k++) begin
                if (done || busy) seen++;
                step();
            end
            chk("rm_no_done", 64'(seen), 64'd0);
        end
        run_op(100, 2'b11, 6'd1, 64'd1, 64'h8000_0000_0000_0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
